// File: rtl/text_terminal_ctrl.sv
// -----------------------------------------------------------------------------
// text_terminal_ctrl
//
// Sequencer that sits in front of character_buffer. It turns keyboard events
// into cursor movement and character cell writes: printable echo, Enter,
// Backspace, arrow-key movement and a full-screen clear sweep. It owns the
// cursor position.
//
// Ports
//   clk               clock
//   rst               asynchronous, active-high reset
//   ps2_ascii_vld     one-cycle strobe qualifying ps2_ascii
//   ps2_ascii         ASCII code
//   ps2_scancode_vld  one-cycle strobe qualifying ps2_scancode
//   ps2_scancode      PS/2 set-2 scancode
//   clear_req         one-cycle strobe requesting a screen clear
//   char_write_en     buffer write strobe (one cycle per write)
//   char_hpos/vpos    write column/row
//   char_symbol       write data
//   cursor_hpos/vpos  current cursor column/row
//   busy              high while the clear sweep is running
//
// Handshake: every input event is a single-cycle valid strobe with no ready.
// An event is consumed in the cycle it is presented or it is lost: events
// arriving while busy, and lower-priority events that collide with a
// higher-priority one (clear_req > ascii > scancode), are dropped. The
// write port is fire-and-forget; the buffer must take a write every cycle.
//
// Every output is a register. A write caused by an event is visible in the
// cycle after the event, together with the updated cursor.
// -----------------------------------------------------------------------------
module text_terminal_ctrl #(
   parameter int         CHAR_HORZ_CNT = 16,
   parameter int         CHAR_VERT_CNT = 8,
   parameter int         CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
   parameter int         CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
   parameter logic [7:0] BLANK_CHAR    = 8'h20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ps2_ascii_vld,
   input  logic [7:0]             ps2_ascii,
   input  logic                   ps2_scancode_vld,
   input  logic [7:0]             ps2_scancode,
   input  logic                   clear_req,
   output logic                   char_write_en,
   output logic [CHAR_HORZ_W-1:0] char_hpos,
   output logic [CHAR_VERT_W-1:0] char_vpos,
   output logic [7:0]             char_symbol,
   output logic [CHAR_HORZ_W-1:0] cursor_hpos,
   output logic [CHAR_VERT_W-1:0] cursor_vpos,
   output logic                   busy
);

   // Last valid indices and a width-matched one. Wrapping and saturation use
   // explicit compares against these, so a non-power-of-2 count never yields
   // an out-of-range index.
   localparam logic [CHAR_HORZ_W-1:0] H_MAX = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
   localparam logic [CHAR_VERT_W-1:0] V_MAX = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
   localparam logic [CHAR_HORZ_W-1:0] H_ONE = CHAR_HORZ_W'(1);
   localparam logic [CHAR_VERT_W-1:0] V_ONE = CHAR_VERT_W'(1);

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_ESC   = 8'h1B;
   localparam logic [7:0] ASCII_FIRST = 8'h20;
   localparam logic [7:0] ASCII_LAST  = 8'h7E;

   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // state_q is the FSM state register, kept as a named enum so checkers
   // can bind to it directly.
   state_t state_q;
   state_t state_d;

   // Clear sweep position.
   logic [CHAR_HORZ_W-1:0] sweep_h;
   logic [CHAR_VERT_W-1:0] sweep_v;

   // Next values of all registers.
   logic                   wr_en_d;
   logic [CHAR_HORZ_W-1:0] wr_h_d;
   logic [CHAR_VERT_W-1:0] wr_v_d;
   logic [7:0]             wr_sym_d;
   logic [CHAR_HORZ_W-1:0] cur_h_d;
   logic [CHAR_VERT_W-1:0] cur_v_d;
   logic                   busy_d;
   logic [CHAR_HORZ_W-1:0] sweep_h_d;
   logic [CHAR_VERT_W-1:0] sweep_v_d;

   logic start_clear;
   logic sweep_last;
   logic ascii_printable;

   // Column step with wrap to 0.
   function automatic logic [CHAR_HORZ_W-1:0] wrap_inc_h(input logic [CHAR_HORZ_W-1:0] h);
      return (h == H_MAX) ? '0 : h + H_ONE;
   endfunction

   // Row step with wrap to the top row.
   function automatic logic [CHAR_VERT_W-1:0] wrap_inc_v(input logic [CHAR_VERT_W-1:0] v);
      return (v == V_MAX) ? '0 : v + V_ONE;
   endfunction

   // Both clear_req and ESC start a sweep; clear_req wins over any ASCII
   // event, and ESC is itself an ASCII event, so either way lower-priority
   // events in this cycle are dropped.
   assign start_clear = (state_q == IDLE) &&
                        (clear_req || (ps2_ascii_vld && (ps2_ascii == ASCII_ESC)));
   assign sweep_last  = (sweep_h == H_MAX) && (sweep_v == V_MAX);
   assign ascii_printable = (ps2_ascii >= ASCII_FIRST) && (ps2_ascii <= ASCII_LAST);

   // ---------------------------------------------------------------------------
   // State register (plus the registered datapath and outputs)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         sweep_h       <= '0;
         sweep_v       <= '0;
         char_write_en <= 1'b0;
         char_hpos     <= '0;
         char_vpos     <= '0;
         char_symbol   <= '0;
         cursor_hpos   <= '0;
         cursor_vpos   <= '0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_d;
         sweep_h       <= sweep_h_d;
         sweep_v       <= sweep_v_d;
         char_write_en <= wr_en_d;
         char_hpos     <= wr_h_d;
         char_vpos     <= wr_v_d;
         char_symbol   <= wr_sym_d;
         cursor_hpos   <= cur_h_d;
         cursor_vpos   <= cur_v_d;
         busy          <= busy_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_clear) state_d = CLEAR;
         CLEAR:   if (sweep_last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output / datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // Write address and data hold their last value unless a write happens.
      wr_en_d   = 1'b0;
      wr_h_d    = char_hpos;
      wr_v_d    = char_vpos;
      wr_sym_d  = char_symbol;
      cur_h_d   = cursor_hpos;
      cur_v_d   = cursor_vpos;
      busy_d    = busy;
      sweep_h_d = sweep_h;
      sweep_v_d = sweep_v;

      case (state_q)
         IDLE: begin
            if (start_clear) begin
               busy_d    = 1'b1;
               sweep_h_d = '0;
               sweep_v_d = '0;
            end else if (ps2_ascii_vld) begin
               if (ascii_printable) begin
                  // Echo at the old cursor, then advance with wrap.
                  wr_en_d  = 1'b1;
                  wr_h_d   = cursor_hpos;
                  wr_v_d   = cursor_vpos;
                  wr_sym_d = ps2_ascii;
                  cur_h_d  = wrap_inc_h(cursor_hpos);
                  if (cursor_hpos == H_MAX) begin
                     cur_v_d = wrap_inc_v(cursor_vpos);
                  end
               end else if (ps2_ascii == ASCII_CR) begin
                  cur_h_d = '0;
                  cur_v_d = wrap_inc_v(cursor_vpos);
               end else if (ps2_ascii == ASCII_BS) begin
                  // Retreat one cell (stopping at the home cell), then blank
                  // the cell the cursor lands on.
                  if (cursor_hpos != '0) begin
                     cur_h_d = cursor_hpos - H_ONE;
                  end else if (cursor_vpos != '0) begin
                     cur_h_d = H_MAX;
                     cur_v_d = cursor_vpos - V_ONE;
                  end
                  wr_en_d  = 1'b1;
                  wr_h_d   = cur_h_d;
                  wr_v_d   = cur_v_d;
                  wr_sym_d = BLANK_CHAR;
               end
            end else if (ps2_scancode_vld) begin
               // Arrow keys saturate at the screen edges and never write.
               case (ps2_scancode)
                  SC_LEFT:  if (cursor_hpos != '0)    cur_h_d = cursor_hpos - H_ONE;
                  SC_RIGHT: if (cursor_hpos != H_MAX) cur_h_d = cursor_hpos + H_ONE;
                  SC_UP:    if (cursor_vpos != '0)    cur_v_d = cursor_vpos - V_ONE;
                  SC_DOWN:  if (cursor_vpos != V_MAX) cur_v_d = cursor_vpos + V_ONE;
                  default:  ;
               endcase
            end
         end

         CLEAR: begin
            // One blank per cycle in row-major order; the cursor keeps its
            // pre-clear position until the final cell is written.
            wr_en_d  = 1'b1;
            wr_h_d   = sweep_h;
            wr_v_d   = sweep_v;
            wr_sym_d = BLANK_CHAR;
            if (sweep_last) begin
               busy_d    = 1'b0;
               cur_h_d   = '0;
               cur_v_d   = '0;
               sweep_h_d = '0;
               sweep_v_d = '0;
            end else begin
               sweep_h_d = wrap_inc_h(sweep_h);
               if (sweep_h == H_MAX) begin
                  sweep_v_d = sweep_v + V_ONE;
               end
            end
         end

         default: ;
      endcase
   end

endmodule

// File: tb/tb_text_terminal_ctrl.sv
// -----------------------------------------------------------------------------
// tb_text_terminal_ctrl
//
// Directed bench for text_terminal_ctrl on a 16x8 screen. Inputs change and
// outputs are sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_text_terminal_ctrl;

   localparam int H_CNT = 16;
   localparam int V_CNT = 8;

   // Clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       ps2_ascii_vld    = 1'b0;
   logic [7:0] ps2_ascii        = 8'h00;
   logic       ps2_scancode_vld = 1'b0;
   logic [7:0] ps2_scancode     = 8'h00;
   logic       clear_req        = 1'b0;
   logic       char_write_en;
   logic [3:0] char_hpos;
   logic [2:0] char_vpos;
   logic [7:0] char_symbol;
   logic [3:0] cursor_hpos;
   logic [2:0] cursor_vpos;
   logic       busy;

   int checks = 0;
   int errors = 0;

   text_terminal_ctrl #(
      .CHAR_HORZ_CNT(H_CNT),
      .CHAR_VERT_CNT(V_CNT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .ps2_ascii_vld    (ps2_ascii_vld),
      .ps2_ascii        (ps2_ascii),
      .ps2_scancode_vld (ps2_scancode_vld),
      .ps2_scancode     (ps2_scancode),
      .clear_req        (clear_req),
      .char_write_en    (char_write_en),
      .char_hpos        (char_hpos),
      .char_vpos        (char_vpos),
      .char_symbol      (char_symbol),
      .cursor_hpos      (cursor_hpos),
      .cursor_vpos      (cursor_vpos),
      .busy             (busy)
   );

   // ---------------------------------------------------------------------------
   // Check helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_write(input string tag, input int h, input int v, input int sym);
      check({tag, ".en"},  32'(char_write_en), 32'd1);
      check({tag, ".h"},   32'(char_hpos),     32'(h));
      check({tag, ".v"},   32'(char_vpos),     32'(v));
      check({tag, ".sym"}, 32'(char_symbol),   32'(sym));
   endtask

   task automatic expect_no_write(input string tag);
      check({tag, ".en"}, 32'(char_write_en), 32'd0);
   endtask

   task automatic expect_cursor(input string tag, input int h, input int v);
      check({tag, ".cur_h"}, 32'(cursor_hpos), 32'(h));
      check({tag, ".cur_v"}, 32'(cursor_vpos), 32'(v));
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_ascii(input logic [7:0] code);
      ps2_ascii_vld = 1'b1;
      ps2_ascii     = code;
      tick();
      ps2_ascii_vld = 1'b0;
   endtask

   task automatic send_scan(input logic [7:0] code);
      ps2_scancode_vld = 1'b1;
      ps2_scancode     = code;
      tick();
      ps2_scancode_vld = 1'b0;
   endtask

   // Move the cursor to (h,v) using only saturating arrow keys.
   task automatic goto_cell(input int h, input int v);
      for (int i = 0; i < H_CNT - 1; i++) send_scan(8'h6B);
      for (int i = 0; i < V_CNT - 1; i++) send_scan(8'h75);
      for (int i = 0; i < h; i++)         send_scan(8'h74);
      for (int i = 0; i < v; i++)         send_scan(8'h72);
   endtask

   // Random traffic that must be ignored during a clear sweep.
   task automatic drive_noise();
      logic [7:0] scans [4];
      scans[0] = 8'h6B; scans[1] = 8'h74; scans[2] = 8'h75; scans[3] = 8'h72;
      ps2_ascii_vld    = 1'($urandom_range(0, 1));
      ps2_ascii        = ($urandom_range(0, 3) == 0) ? 8'h1B : 8'($urandom_range(32, 126));
      ps2_scancode_vld = 1'($urandom_range(0, 1));
      ps2_scancode     = scans[$urandom_range(0, 3)];
      clear_req        = 1'($urandom_range(0, 1));
   endtask

   task automatic quiet_inputs();
      ps2_ascii_vld    = 1'b0;
      ps2_scancode_vld = 1'b0;
      clear_req        = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      // Reset state
      tick();
      tick();
      check("rst.en",   32'(char_write_en), 32'd0);
      check("rst.busy", 32'(busy),          32'd0);
      check("rst.h",    32'(char_hpos),     32'd0);
      check("rst.v",    32'(char_vpos),     32'd0);
      check("rst.sym",  32'(char_symbol),   32'd0);
      expect_cursor("rst", 0, 0);
      rst = 1'b0;
      tick();
      expect_no_write("rst_rel");
      expect_cursor("rst_rel", 0, 0);

      // 1. 'A' echoes at (0,0), cursor advances
      send_ascii(8'h41);
      expect_write("t1.A", 0, 0, 8'h41);
      expect_cursor("t1.A", 1, 0);
      tick();
      expect_no_write("t1.idle");
      check("t1.sym_hold", 32'(char_symbol), 32'h41);

      // 2. Fill the rest of row 0; cursor wraps to (0,1)
      for (int i = 1; i < H_CNT; i++) begin
         send_ascii(8'(8'h41 + i));
         expect_write("t2.row", i, 0, 8'h41 + i);
      end
      expect_cursor("t2.row_end", 0, 1);
      goto_cell(15, 7);
      expect_cursor("t2.goto", 15, 7);
      send_ascii(8'h5A);
      expect_write("t2.last", 15, 7, 8'h5A);
      expect_cursor("t2.last", 0, 0);

      // Enter: mid-screen and on the last row
      goto_cell(3, 0);
      send_ascii(8'h0D);
      expect_no_write("t2.cr");
      expect_cursor("t2.cr", 0, 1);
      goto_cell(9, 7);
      send_ascii(8'h0D);
      expect_no_write("t2.cr_wrap");
      expect_cursor("t2.cr_wrap", 0, 0);

      // 3. Backspace
      goto_cell(5, 2);
      send_ascii(8'h08);
      expect_write("t3.bs", 4, 2, 8'h20);
      expect_cursor("t3.bs", 4, 2);
      goto_cell(0, 1);
      send_ascii(8'h08);
      expect_write("t3.bs_row", 15, 0, 8'h20);
      expect_cursor("t3.bs_row", 15, 0);
      goto_cell(0, 0);
      send_ascii(8'h08);
      expect_write("t3.bs_home", 0, 0, 8'h20);
      expect_cursor("t3.bs_home", 0, 0);

      // 4. Arrow keys saturate; priority; ignored codes
      send_scan(8'h6B);
      expect_cursor("t4.left0", 0, 0);
      send_scan(8'h75);
      expect_cursor("t4.up0", 0, 0);
      for (int i = 0; i < 20; i++) send_scan(8'h74);
      expect_cursor("t4.right20", 15, 0);
      expect_no_write("t4.right20");
      // ASCII and scancode together: only the echo happens
      ps2_scancode_vld = 1'b1;
      ps2_scancode     = 8'h72;
      send_ascii(8'h43);
      ps2_scancode_vld = 1'b0;
      expect_write("t4.both", 15, 0, 8'h43);
      expect_cursor("t4.both", 0, 1);
      send_scan(8'h1C);
      expect_cursor("t4.scan_other", 0, 1);
      send_ascii(8'h7F);
      expect_no_write("t4.del");
      expect_cursor("t4.del", 0, 1);
      check("t4.hold_h",   32'(char_hpos),   32'd15);
      check("t4.hold_v",   32'(char_vpos),   32'd0);
      check("t4.hold_sym", 32'(char_symbol), 32'h43);
      send_ascii(8'h1F);
      expect_no_write("t4.ctl");
      send_ascii(8'h7E);
      expect_write("t4.tilde", 0, 1, 8'h7E);
      expect_cursor("t4.tilde", 1, 1);
      send_ascii(8'h20);
      expect_write("t4.space", 1, 1, 8'h20);
      expect_cursor("t4.space", 2, 1);
      for (int i = 0; i < 10; i++) send_scan(8'h72);
      expect_cursor("t4.down_sat", 2, 7);

      // 5. Full clear with an ASCII event colliding with clear_req
      goto_cell(3, 3);
      clear_req = 1'b1;
      send_ascii(8'h51);
      clear_req = 1'b0;
      expect_no_write("t5.start");
      check("t5.start.busy", 32'(busy), 32'd1);
      expect_cursor("t5.start", 3, 3);
      for (int i = 0; i < H_CNT * V_CNT; i++) begin
         drive_noise();
         tick();
         quiet_inputs();
         expect_write("t5.sweep", i % H_CNT, i / H_CNT, 8'h20);
         if (i < H_CNT * V_CNT - 1) begin
            check("t5.sweep.busy", 32'(busy), 32'd1);
            expect_cursor("t5.sweep", 3, 3);
         end else begin
            check("t5.end.busy", 32'(busy), 32'd0);
            expect_cursor("t5.end", 0, 0);
         end
      end
      tick();
      expect_no_write("t5.after");
      check("t5.after.busy", 32'(busy), 32'd0);
      expect_cursor("t5.after", 0, 0);
      send_ascii(8'h44);
      expect_write("t5.echo", 0, 0, 8'h44);

      // 6. ESC starts a sweep; reset at sweep cycle 40 aborts it
      goto_cell(6, 4);
      send_ascii(8'h1B);
      check("t6.start.busy", 32'(busy), 32'd1);
      expect_no_write("t6.start");
      for (int i = 0; i < 40; i++) tick();
      expect_write("t6.sweep40", 39 % H_CNT, 39 / H_CNT, 8'h20);
      expect_cursor("t6.sweep40", 6, 4);
      #3;
      rst = 1'b1;
      #1;
      check("t6.rst.busy", 32'(busy), 32'd0);
      expect_no_write("t6.rst");
      expect_cursor("t6.rst", 0, 0);
      tick();
      rst = 1'b0;
      tick();
      expect_no_write("t6.rel");
      check("t6.rel.busy", 32'(busy), 32'd0);
      send_ascii(8'h42);
      expect_write("t6.B", 0, 0, 8'h42);
      expect_cursor("t6.B", 1, 0);
      tick();
      expect_no_write("t6.quiet");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
